// File: rtl/lc3_host_link_pkg.sv
// Shared opcodes, reply code and state encodings for the LC-3 host link.
package lc3_host_link_pkg;

   localparam logic [2:0] OP_STATUS  = 3'd1;
   localparam logic [2:0] OP_RUN     = 3'd2;
   localparam logic [2:0] OP_STOP    = 3'd3;
   localparam logic [2:0] OP_LOAD    = 3'd4;
   localparam logic [2:0] OP_DUMP    = 3'd5;
   localparam logic [2:0] OP_RESTART = 3'd6;
   localparam logic [7:0] REPLY_OK   = 8'h00;

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_FETCH, S_WAIT_REPLY, S_RECV_HI, S_RECV_LO, S_FINISH
   } link_state_e;

   typedef enum logic [2:0] {
      P_IDLE, P_WAIT_FREE, P_WAIT_RISE, P_WAIT_FALL, P_GAP
   } pacer_state_e;

   function automatic logic op_known(input logic [2:0] op);
      return (op != 3'd0) && (op != 3'd7);
   endfunction

   function automatic logic op_is_range(input logic [2:0] op);
      return (op == OP_LOAD) || (op == OP_DUMP);
   endfunction

endpackage

// File: rtl/lc3_tx_pacer.sv
// One-byte uart_tx handshake: wait idle, pulse start, follow busy high then low, then idle BYTE_GAP cycles.
module lc3_tx_pacer
   import lc3_host_link_pkg::*;
#(
   parameter logic [7:0] BYTE_GAP = 8'd16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       send_i,
   input  logic [7:0] byte_in_i,
   output logic       ready_o,
   output logic       tx_start_o,
   output logic [7:0] tx_data_o,
   input  logic       tx_busy_i
);
   pacer_state_e state_q, state_d;
   logic [7:0]   byte_q;
   logic [7:0]   gap_q;
   logic         tx_start_q;
   logic [7:0]   tx_data_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= P_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         P_IDLE:      if (send_i) state_d = P_WAIT_FREE;
         P_WAIT_FREE: if (!tx_busy_i) state_d = P_WAIT_RISE;
         P_WAIT_RISE: if (tx_busy_i) state_d = P_WAIT_FALL;
         P_WAIT_FALL: if (!tx_busy_i) state_d = (BYTE_GAP == 8'd0) ? P_IDLE : P_GAP;
         P_GAP:       if (gap_q == BYTE_GAP - 8'd1) state_d = P_IDLE;
         default:     state_d = P_IDLE;
      endcase
   end

   always_comb begin
      ready_o    = (state_q == P_IDLE);
      tx_start_o = tx_start_q;
      tx_data_o  = tx_data_q;
   end

   // tx_data only changes together with tx_start, so it stays stable for the whole byte.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         byte_q     <= '0;
         gap_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_start_q <= 1'b0;
         if (state_q == P_IDLE && send_i) byte_q <= byte_in_i;
         if (state_q == P_WAIT_FREE && !tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= byte_q;
         end
         gap_q <= (state_q == P_GAP) ? gap_q + 8'd1 : 8'd0;
      end
   end

endmodule

// File: rtl/lc3_host_link.sv
// Host-side LC-3 board link: serialises one command at a time to uart_tx and parses board replies.
module lc3_host_link
   import lc3_host_link_pkg::*;
#(
   parameter logic [23:0] ACK_TIMEOUT = 24'd12_000_000,
   parameter logic [7:0]  BYTE_GAP    = 8'd16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [2:0]  cmd_op_i,
   input  logic [15:0] cmd_min_i,
   input  logic [15:0] cmd_max_i,
   output logic [15:0] src_addr_o,
   input  logic [15:0] src_data_i,
   output logic        snk_we_o,
   output logic [15:0] snk_addr_o,
   output logic [15:0] snk_data_o,
   output logic        tx_start_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_busy_i,
   input  logic        rx_ready_i,
   input  logic [7:0]  rx_data_i,
   output logic [7:0]  status_byte_o,
   output logic        done_o,
   output logic        err_o
);
   link_state_e state_q, state_d;
   logic [2:0]  op_q;
   logic [15:0] max_q;
   logic [16:0] addr_q;
   logic [7:0]  buf_q [0:7];
   logic [7:0]  load_bytes [0:7];
   logic [2:0]  n_q, idx_q;
   logic        data_ph_q, fetch_ph_q, err_q, snk_we_q;
   logic [7:0]  hi_q, status_q;
   logic [15:0] snk_addr_q, snk_data_q;
   logic [23:0] to_q;
   logic        pace_ready, pace_send, cmd_fire, cmd_bad, send_done;
   logic        waiting, timeout, at_max, buf_load;

   lc3_tx_pacer #(.BYTE_GAP(BYTE_GAP)) u_pacer (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .send_i     (pace_send),
      .byte_in_i  (buf_q[idx_q]),
      .ready_o    (pace_ready),
      .tx_start_o (tx_start_o),
      .tx_data_o  (tx_data_o),
      .tx_busy_i  (tx_busy_i)
   );

   always_comb begin
      cmd_fire  = cmd_valid_i && (state_q == S_IDLE);
      cmd_bad   = !op_known(cmd_op_i) || (op_is_range(cmd_op_i) && (cmd_min_i > cmd_max_i));
      pace_send = (state_q == S_SEND) && pace_ready && (idx_q != n_q);
      send_done = (state_q == S_SEND) && pace_ready && (idx_q == n_q);
      waiting   = (state_q == S_WAIT_REPLY) || (state_q == S_RECV_HI) || (state_q == S_RECV_LO);
      timeout   = waiting && !rx_ready_i && (to_q == ACK_TIMEOUT - 24'd1);
      at_max    = (addr_q[15:0] == max_q);
      buf_load  = cmd_fire || ((state_q == S_FETCH) && fetch_ph_q);
      for (int i = 0; i < 8; i++) load_bytes[i] = 8'h00;
      // The byte queue holds either the command header or one fetched word, hi first.
      if (state_q == S_FETCH) begin
         load_bytes[0] = src_data_i[15:8];
         load_bytes[1] = src_data_i[7:0];
      end else begin
         load_bytes[0] = {5'd0, cmd_op_i};
         load_bytes[1] = cmd_min_i[15:8];
         load_bytes[2] = cmd_min_i[7:0];
         load_bytes[3] = cmd_max_i[15:8];
         load_bytes[4] = cmd_max_i[7:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_fire) state_d = cmd_bad ? S_FINISH : S_SEND;
         S_SEND: if (send_done) begin
            if (op_q == OP_DUMP)                             state_d = S_RECV_HI;
            else if (op_q == OP_LOAD && !(data_ph_q && at_max)) state_d = S_FETCH;
            else                                             state_d = S_WAIT_REPLY;
         end
         S_FETCH:      if (fetch_ph_q) state_d = S_SEND;
         S_WAIT_REPLY: if (rx_ready_i || timeout) state_d = S_FINISH;
         S_RECV_HI: begin
            if (rx_ready_i)   state_d = S_RECV_LO;
            else if (timeout) state_d = S_FINISH;
         end
         S_RECV_LO: begin
            if (rx_ready_i)   state_d = at_max ? S_FINISH : S_RECV_HI;
            else if (timeout) state_d = S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o   = (state_q == S_IDLE);
      done_o        = (state_q == S_FINISH);
      err_o         = err_q;
      src_addr_o    = addr_q[15:0];
      snk_we_o      = snk_we_q;
      snk_addr_o    = snk_addr_q;
      snk_data_o    = snk_data_q;
      status_byte_o = status_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         op_q <= '0; max_q <= '0; addr_q <= '0; n_q <= '0; idx_q <= '0;
         data_ph_q <= 1'b0; fetch_ph_q <= 1'b0; err_q <= 1'b0; snk_we_q <= 1'b0;
         hi_q <= '0; status_q <= '0; snk_addr_q <= '0; snk_data_q <= '0; to_q <= '0;
         for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      end else begin
         snk_we_q <= 1'b0;
         // Reloads whenever not waiting and on every received byte.
         to_q <= (waiting && !rx_ready_i) ? to_q + 24'd1 : 24'd0;
         if (buf_load) for (int i = 0; i < 8; i++) buf_q[i] <= load_bytes[i];
         if (cmd_fire) begin
            op_q      <= cmd_op_i;
            max_q     <= cmd_max_i;
            addr_q    <= {1'b0, cmd_min_i};
            err_q     <= cmd_bad;
            data_ph_q <= 1'b0;
            idx_q     <= 3'd0;
            n_q       <= op_is_range(cmd_op_i) ? 3'd5 : 3'd1;
         end
         if (pace_send) idx_q <= idx_q + 3'd1;
         if (send_done && op_q == OP_LOAD) begin
            data_ph_q <= 1'b1;
            if (data_ph_q && !at_max) addr_q <= addr_q + 17'd1;
         end
         if (state_q == S_FETCH) begin
            fetch_ph_q <= ~fetch_ph_q;
            if (fetch_ph_q) begin
               n_q   <= 3'd2;
               idx_q <= 3'd0;
            end
         end
         if (timeout) err_q <= 1'b1;
         if (rx_ready_i) begin
            case (state_q)
               S_WAIT_REPLY: begin
                  if (op_q == OP_STATUS)          status_q <= rx_data_i;
                  else if (rx_data_i != REPLY_OK) err_q    <= 1'b1;
               end
               S_RECV_HI: hi_q <= rx_data_i;
               S_RECV_LO: begin
                  snk_we_q   <= 1'b1;
                  snk_addr_q <= addr_q[15:0];
                  snk_data_q <= {hi_q, rx_data_i};
                  if (!at_max) addr_q <= addr_q + 17'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lc3_host_link.sv
// Scoreboard bench for lc3_host_link with a loopback UART and a behavioural board model.
module tb_lc3_host_link;
   localparam logic [23:0] ACK_TO = 24'd100;
   localparam logic [7:0]  GAP    = 8'd4;

   logic        clk = 1'b0;
   logic        reset, cmd_valid, cmd_ready, snk_we, tx_start, tx_busy, rx_ready, done, err;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_min, cmd_max, src_addr, src_data, snk_addr, snk_data;
   logic [7:0]  tx_data, rx_data, status_byte;

   always #5 clk = ~clk;

   lc3_host_link #(.ACK_TIMEOUT(ACK_TO), .BYTE_GAP(GAP)) dut (
      .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_min_i(cmd_min), .cmd_max_i(cmd_max),
      .src_addr_o(src_addr), .src_data_i(src_data),
      .snk_we_o(snk_we), .snk_addr_o(snk_addr), .snk_data_o(snk_data),
      .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
      .rx_ready_i(rx_ready), .rx_data_i(rx_data),
      .status_byte_o(status_byte), .done_o(done), .err_o(err)
   );

   typedef struct { logic [15:0] addr; logic [15:0] data; } snk_t;
   typedef struct { logic err; logic [7:0] status; } done_t;

   logic [7:0]  exp_tx[$];
   snk_t        exp_snk[$];
   done_t       exp_done[$];
   logic [7:0]  reply_q[$];
   logic [15:0] src_mem   [0:65535];
   logic [15:0] board_mem [0:65535];
   logic [7:0]  model_status = 8'h00;
   int reply_after = 0, reply_wait = 0, tx_count = 0, done_cnt = 0;
   int cyc = 0, last_fall_cyc = 0, done_cyc = 0;
   int errors = 0, checks = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) src_data <= src_mem[src_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents a byte, a sink write or done.
   always @(negedge clk) begin
      if (!reset) begin
         if (tx_start) begin
            if (exp_tx.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_unexpected actual=%02h required=none", tx_data);
            end else check("tx_byte", tx_data, exp_tx.pop_front());
         end
         if (snk_we) begin
            if (exp_snk.size() == 0) begin
               checks++; errors++;
               $display("FAIL snk_unexpected actual=%04h:%04h required=none", snk_addr, snk_data);
            end else begin
               snk_t s;
               s = exp_snk.pop_front();
               check("snk_addr", snk_addr, s.addr);
               check("snk_data", snk_data, s.data);
            end
         end
         if (done) begin
            if (exp_done.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected actual=1 required=0");
            end else begin
               done_t d;
               d = exp_done.pop_front();
               check("done_err", err, d.err);
               check("done_status", status_byte, d.status);
            end
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // Loopback uart_tx: busy for a few cycles after each start pulse.
   initial begin
      int busy_cnt;
      busy_cnt = 0;
      tx_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               tx_busy = 1'b0;
               tx_count++;
               last_fall_cyc = cyc;
            end
         end else if (tx_start) begin
            tx_busy = 1'b1;
            busy_cnt = $urandom_range(2, 5);
         end
      end
   end

   // Board model: once the expected request bytes are out, plays back the queued reply bytes.
   initial begin
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      forever begin
         @(posedge clk); #1;
         rx_ready = 1'b0;
         if (reply_q.size() > 0 && tx_count >= reply_after) begin
            if (reply_wait > 0) reply_wait--;
            else begin
               rx_ready   = 1'b1;
               rx_data    = reply_q.pop_front();
               reply_wait = $urandom_range(1, 5);
            end
         end
      end
   end

   // reply: byte the board answers with (-1 = silent); dump_words: words returned by DUMP (-1 = all).
   task automatic run_cmd(input logic [2:0] op, input logic [15:0] mn, input logic [15:0] mx,
                          input int reply, input int dump_words);
      logic  bad, exp_err;
      int    n, nret, k, start;
      done_t d;
      bad = (op == 3'd0 || op == 3'd7) || ((op == 3'd4 || op == 3'd5) && mn > mx);
      n = int'(mx) - int'(mn) + 1;
      exp_err = bad;
      @(posedge clk); #1;
      tx_count = 0; reply_after = 1; reply_wait = int'(GAP) + 6; reply_q.delete();
      if (!bad) begin
         exp_tx.push_back({5'd0, op});
         if (op == 3'd4 || op == 3'd5) begin
            exp_tx.push_back(mn[15:8]); exp_tx.push_back(mn[7:0]);
            exp_tx.push_back(mx[15:8]); exp_tx.push_back(mx[7:0]);
         end
         case (op)
            3'd4: begin
               for (int a = int'(mn); a <= int'(mx); a++) begin
                  exp_tx.push_back(src_mem[a][15:8]);
                  exp_tx.push_back(src_mem[a][7:0]);
               end
               reply_after = 5 + 2 * n;
               if (reply >= 0) reply_q.push_back(8'(reply));
               exp_err = (reply != 0);
            end
            3'd5: begin
               reply_after = 5;
               nret = (dump_words < 0 || dump_words > n) ? n : dump_words;
               for (int i = 0; i < nret; i++) begin
                  snk_t s;
                  s.addr = 16'(int'(mn) + i);
                  s.data = board_mem[int'(mn) + i];
                  reply_q.push_back(s.data[15:8]);
                  reply_q.push_back(s.data[7:0]);
                  exp_snk.push_back(s);
               end
               exp_err = (nret < n);
            end
            3'd1: begin
               if (reply >= 0) begin
                  reply_q.push_back(8'(reply));
                  model_status = 8'(reply);
               end
               exp_err = (reply < 0);
            end
            default: begin
               if (reply >= 0) reply_q.push_back(8'(reply));
               exp_err = (reply != 0);
            end
         endcase
      end
      d.err = exp_err; d.status = model_status;
      exp_done.push_back(d);
      check("cmd_ready", cmd_ready, 1'b1);
      cmd_op = op; cmd_min = mn; cmd_max = mx; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("accept_err", err, bad);
      start = done_cnt; k = 0;
      while (done_cnt == start && k < 4000) begin
         @(posedge clk);
         k++;
      end
      checks++;
      if (done_cnt == start) begin
         errors++;
         $display("FAIL done_timeout actual=none required=done");
      end
      check("tx_left", exp_tx.size(), 0);
      check("snk_left", exp_snk.size(), 0);
      exp_tx.delete(); exp_snk.delete(); exp_done.delete(); reply_q.delete();
      $display("cmd op=%0d min=%04h max=%04h err=%0b status=%02h", op, mn, mx, err, status_byte);
   endtask

   initial begin
      logic [2:0]  op;
      logic [15:0] mn, mx;
      int base, len, rep, dw, k;
      for (int i = 0; i < 65536; i++) begin
         src_mem[i]   = 16'($urandom);
         board_mem[i] = 16'($urandom);
      end
      src_mem[16'h3000] = 16'h1234; src_mem[16'h3001] = 16'hABCD; src_mem[16'h3002] = 16'hF025;
      board_mem[16'hFFFE] = 16'hBEEF; board_mem[16'hFFFF] = 16'hCAFE;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_min = '0; cmd_max = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_flags", {cmd_ready, done, err, tx_start, snk_we}, 5'b10000);
      check("rst_words", {status_byte, tx_data, src_addr, snk_addr, snk_data}, 64'h0);

      run_cmd(3'd1, 16'h0, 16'h0, 8'h04, -1);
      run_cmd(3'd4, 16'h3000, 16'h3002, 0, -1);
      run_cmd(3'd5, 16'hFFFE, 16'hFFFF, 0, -1);
      run_cmd(3'd2, 16'h0, 16'h0, 8'h07, -1);
      check("err_sticky", err, 1'b1);
      run_cmd(3'd1, 16'h0, 16'h0, 8'h5C, -1);
      run_cmd(3'd3, 16'h0, 16'h0, -1, -1);
      check("timeout_window",
            ((done_cyc - last_fall_cyc) >= int'(ACK_TO) &&
             (done_cyc - last_fall_cyc) <= int'(ACK_TO) + int'(GAP) + 10), 1'b1);
      run_cmd(3'd4, 16'h0010, 16'h000F, 0, -1);
      run_cmd(3'd0, 16'h0, 16'h0, 0, -1);
      run_cmd(3'd5, 16'h0100, 16'h0100, 0, -1);

      // A stray reply byte while idle must be ignored.
      @(posedge clk); #2;
      rx_ready = 1'b1; rx_data = 8'hA5;
      @(posedge clk); #2;
      check("idle_rx_status", status_byte, model_status);
      check("idle_rx_ready", cmd_ready, 1'b1);

      // Reset in the middle of a DUMP header.
      tx_count = 0;
      exp_tx.push_back(8'h05); exp_tx.push_back(8'h02); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h02); exp_tx.push_back(8'h03);
      cmd_op = 3'd5; cmd_min = 16'h0200; cmd_max = 16'h0203; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      k = 0;
      while (tx_count < 2 && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      check("mid_dump_progress", tx_count >= 2, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ready", cmd_ready, 1'b1);
      check("rst_mid_txstart", tx_start, 1'b0);
      reset = 1'b0;
      exp_tx.delete();
      model_status = 8'h00;
      check("rst_mid_status", status_byte, 8'h00);
      repeat (40) @(posedge clk);
      $display("cmd reset-mid-dump done_cnt=%0d", done_cnt);

      for (int t = 0; t < 30; t++) begin
         op   = 3'($urandom_range(0, 7));
         base = ($urandom_range(0, 3) == 0) ? 65536 - $urandom_range(1, 6) : $urandom_range(0, 65535);
         len  = $urandom_range(1, 6);
         mn   = 16'(base);
         mx   = (base + len - 1 > 65535) ? 16'hFFFF : 16'(base + len - 1);
         if ($urandom_range(0, 7) == 0 && base > 0) mx = mn - 16'd1;
         if (op == 3'd1) rep = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 255) : -1;
         else begin
            k = $urandom_range(0, 9);
            rep = (k < 6) ? 0 : (k < 8) ? $urandom_range(1, 255) : -1;
         end
         dw = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
         run_cmd(op, mn, mx, rep, dw);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
